// File: rtl/csr_reg_if.sv
// csr_reg_if: CSR read/write port shared by the write-back stage (writes),
// the CSR forwarding stage (reads) and the machine-mode CSR file.
interface csr_reg_if;
  logic        w_csr_req_i;
  logic [11:0] w_csr_addr_i;
  logic [31:0] w_csr_data_i;
  logic [11:0] r_csr_addr_i;
  logic [31:0] r_csr_data_o;
  logic        r_csr_illegal_o;

  modport master (
    output w_csr_req_i, w_csr_addr_i, w_csr_data_i, r_csr_addr_i,
    input  r_csr_data_o, r_csr_illegal_o
  );

  modport slave (
    input  w_csr_req_i, w_csr_addr_i, w_csr_data_i, r_csr_addr_i,
    output r_csr_data_o, r_csr_illegal_o
  );
endinterface

// File: rtl/csr_reg.sv
// csr_reg: machine-mode CSR file. Holds mstatus/misa/mie/mtvec/mscratch/
// mepc/mcause/mhartid, sequences trap entry and mret, and (when the macro
// CSR_COUNTER_EN is defined) the 64-bit mcycle/minstret counters with their
// read-only user shadows. Reads are combinational and show the state at the
// start of the cycle; the downstream forwarding stage covers same-cycle writes.
module csr_reg #(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_reg_if.slave    csr,
  input  logic        retire_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        global_ie_o
);
  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        trap_owns;
  logic        status_mie;
  logic        status_mpie;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] rd_data;
  logic        rd_illegal;

  assign wr_en   = csr.w_csr_req_i;
  assign wr_addr = csr.w_csr_addr_i;
  assign wr_data = csr.w_csr_data_i;

  // A trap or mret cycle owns mstatus/mepc/mcause; software writes to them are dropped
  assign trap_owns = trap_req_i | mret_i;

  // Architectural CSR state: reset, trap entry, mret, then software writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mie_q       <= 32'd0;
      mtvec_q     <= MTVEC_RST;
      mscratch_q  <= 32'd0;
      mepc_q      <= 32'd0;
      mcause_q    <= 32'd0;
    end else begin
      if (wr_en && wr_addr == A_MIE)      mie_q      <= wr_data;
      if (wr_en && wr_addr == A_MTVEC)    mtvec_q    <= {wr_data[31:2], 2'b00};
      if (wr_en && wr_addr == A_MSCRATCH) mscratch_q <= wr_data;
      if (trap_req_i) begin
        mepc_q      <= {trap_pc_i[31:2], 2'b00};
        mcause_q    <= trap_cause_i;
        status_mpie <= status_mie;
        status_mie  <= 1'b0;
      end else if (mret_i) begin
        status_mie  <= status_mpie;
        status_mpie <= 1'b1;
      end else if (wr_en && !trap_owns) begin
        case (wr_addr)
          A_MSTATUS: begin
            status_mie  <= wr_data[3];
            status_mpie <= wr_data[7];
          end
          A_MEPC:   mepc_q   <= {wr_data[31:2], 2'b00};
          A_MCAUSE: mcause_q <= wr_data;
          default:  ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;
  logic [63:0] mcycle_nxt;
  logic [63:0] minstret_nxt;

  // Full 64-bit increment first so the carry crosses halves in one cycle; a written half then overrides its own bits
  always_comb begin
    mcycle_nxt   = mcycle_q + 64'd1;
    minstret_nxt = minstret_q + {63'd0, retire_i};
    if (wr_en) begin
      case (wr_addr)
        A_MCYCLE:    mcycle_nxt[31:0]    = wr_data;
        A_MCYCLEH:   mcycle_nxt[63:32]   = wr_data;
        A_MINSTRET:  minstret_nxt[31:0]  = wr_data;
        A_MINSTRETH: minstret_nxt[63:32] = wr_data;
        default:     ;
      endcase
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_nxt;
      minstret_q <= minstret_nxt;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  // Combinational read mux; unmapped addresses read 0 and flag illegal
  always_comb begin
    rd_data    = 32'd0;
    rd_illegal = 1'b0;
    case (csr.r_csr_addr_i)
      A_MSTATUS:  rd_data = {24'd0, status_mpie, 3'd0, status_mie, 3'd0};
      A_MISA:     rd_data = MISA_VAL;
      A_MIE:      rd_data = mie_q;
      A_MTVEC:    rd_data = mtvec_q;
      A_MSCRATCH: rd_data = mscratch_q;
      A_MEPC:     rd_data = mepc_q;
      A_MCAUSE:   rd_data = mcause_q;
      A_MHARTID:  rd_data = HART_ID;
`ifdef CSR_COUNTER_EN
      A_MCYCLE,    A_CYCLE:    rd_data = mcycle_q[31:0];
      A_MCYCLEH,   A_CYCLEH:   rd_data = mcycle_q[63:32];
      A_MINSTRET,  A_INSTRET:  rd_data = minstret_q[31:0];
      A_MINSTRETH, A_INSTRETH: rd_data = minstret_q[63:32];
`else
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH,
      A_CYCLE, A_CYCLEH, A_INSTRET, A_INSTRETH: rd_data = 32'd0;
`endif
      default: rd_illegal = 1'b1;
    endcase
  end

  assign csr.r_csr_data_o    = rd_data;
  assign csr.r_csr_illegal_o = rd_illegal;
  assign mtvec_o             = mtvec_q;
  assign mepc_o              = mepc_q;
  assign global_ie_o         = status_mie;
endmodule

// File: tb/tb_csr_reg.sv
// tb_csr_reg: randomized and directed checks of csr_reg against an
// address-level reference model held in the bench.
module tb_csr_reg;
  logic        clk;
  logic        rst_n;
  logic        retire;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        global_ie_o;

  csr_reg_if bus ();

  csr_reg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr          (bus),
    .retire_i     (retire),
    .trap_req_i   (trap_req),
    .trap_pc_i    (trap_pc),
    .trap_cause_i (trap_cause),
    .mret_i       (mret),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .global_ie_o  (global_ie_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: CSR contents as whole values
  bit          m_valid = 1'b0;
  logic [31:0] m_mst, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model_read(input logic [11:0] a);
    logic [31:0] d;
    logic        ill;
    d = 32'd0;
    ill = 1'b0;
    case (a)
      12'h300: d = m_mst;
      12'h301: d = 32'h4000_0100;
      12'h304: d = m_mie;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'hF14: d = 32'd0;
`ifdef CSR_COUNTER_EN
      12'hB00, 12'hC00: d = m_cyc[31:0];
      12'hB80, 12'hC80: d = m_cyc[63:32];
      12'hB02, 12'hC02: d = m_ins[31:0];
      12'hB82, 12'hC82: d = m_ins[63:32];
`else
      12'hB00, 12'hC00, 12'hB80, 12'hC80,
      12'hB02, 12'hC02, 12'hB82, 12'hC82: d = 32'd0;
`endif
      default: ill = 1'b1;
    endcase
    return {ill, d};
  endfunction

  task automatic model_update();
    logic [63:0] cyc, ins;
    logic [31:0] wd;
    wd = bus.w_csr_data_i;
    if (!rst_n) begin
      m_mst = 0; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
      m_valid = 1'b1;
    end else begin
      cyc = m_cyc + 64'd1;
      ins = m_ins + (retire ? 64'd1 : 64'd0);
      if (bus.w_csr_req_i) begin
        case (bus.w_csr_addr_i)
          12'h304: m_mie = wd;
          12'h305: m_mtvec = wd & 32'hFFFF_FFFC;
          12'h340: m_mscratch = wd;
          12'hB00: cyc[31:0] = wd;
          12'hB80: cyc[63:32] = wd;
          12'hB02: ins[31:0] = wd;
          12'hB82: ins[63:32] = wd;
          12'h300: if (!trap_req && !mret) m_mst = wd & 32'h88;
          12'h341: if (!trap_req && !mret) m_mepc = wd & 32'hFFFF_FFFC;
          12'h342: if (!trap_req && !mret) m_mcause = wd;
          default: ;
        endcase
      end
      if (trap_req) begin
        m_mepc = trap_pc & 32'hFFFF_FFFC;
        m_mcause = trap_cause;
        m_mst = m_mst[3] ? 32'h80 : 32'h00;
      end else if (mret) begin
        m_mst = m_mst[7] ? 32'h88 : 32'h80;
      end
      m_cyc = cyc;
      m_ins = ins;
    end
  endtask

  task automatic begin_cycle(input logic [11:0] ra);
    @(negedge clk);
    rst_n = 1'b1;
    retire = 1'b0;
    trap_req = 1'b0;
    trap_pc = 32'd0;
    trap_cause = 32'd0;
    mret = 1'b0;
    bus.w_csr_req_i = 1'b0;
    bus.w_csr_addr_i = 12'd0;
    bus.w_csr_data_i = 32'd0;
    bus.r_csr_addr_i = ra;
  endtask

  task automatic write(input logic [11:0] wa, input logic [31:0] wd);
    bus.w_csr_req_i = 1'b1;
    bus.w_csr_addr_i = wa;
    bus.w_csr_data_i = wd;
  endtask

  // Let inputs settle, then compare every observable against the model
  task automatic settle();
    logic [32:0] exp;
    #1;
    if (m_valid) begin
      exp = model_read(bus.r_csr_addr_i);
      check("rdata", bus.r_csr_data_o, exp[31:0]);
      check("illegal", {31'd0, bus.r_csr_illegal_o}, {31'd0, exp[32]});
      check("mtvec_o", mtvec_o, m_mtvec);
      check("mepc_o", mepc_o, m_mepc);
      check("gie", {31'd0, global_ie_o}, {31'd0, m_mst[3]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic peek(input string tag, input logic [11:0] ra, input logic [31:0] exp);
    bus.r_csr_addr_i = ra;
    #1;
    check(tag, bus.r_csr_data_o, exp);
  endtask

  logic [11:0] addrs [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                              12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02,
                              12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                              12'hF14, 12'h7C0, 12'h000, 12'h3FF, 12'hF11};

  initial begin
    // Reset held for two edges
    for (int i = 0; i < 2; i++) begin
      begin_cycle(12'h340);
      rst_n = 1'b0;
      settle();
      tick();
    end
    begin_cycle(12'h340);
    settle();
    check("rst_mtvec", mtvec_o, 32'h0);
    check("rst_mepc", mepc_o, 32'h0);
    check("rst_gie", {31'd0, global_ie_o}, 32'h0);
    check("rst_mscratch", bus.r_csr_data_o, 32'h0);
    tick();

    // mtvec write: low bits cleared, same-cycle read returns old value
    begin_cycle(12'h305);
    write(12'h305, 32'h8000_0103);
    settle();
    check("mtvec_same_cycle", bus.r_csr_data_o, 32'h0);
    tick();
    begin_cycle(12'h305);
    settle();
    check("mtvec_new", mtvec_o, 32'h8000_0100);
    tick();

    // Counter carry across halves
    begin_cycle(12'hB00);
    write(12'hB00, 32'hFFFF_FFFE);
    settle();
    tick();
    begin_cycle(12'hB80);
    write(12'hB80, 32'd5);
    settle();
    tick();
    begin_cycle(12'hB00);
    settle();
    tick();
    begin_cycle(12'hB00);
    settle();
    check("mcycle_lo_wrap", bus.r_csr_data_o, 32'h0);
    check("cnt_illegal", {31'd0, bus.r_csr_illegal_o}, 32'h0);
`ifdef CSR_COUNTER_EN
    peek("mcycleh_carry", 12'hB80, 32'd6);
`else
    peek("mcycleh_carry", 12'hB80, 32'd0);
`endif
    tick();

    // minstret counts retirements
    begin_cycle(12'hB02);
    write(12'hB02, 32'd10);
    settle();
    tick();
    for (int i = 0; i < 3; i++) begin
      begin_cycle(12'hB02);
      retire = 1'b1;
      settle();
      tick();
    end
    begin_cycle(12'hB02);
    settle();
`ifdef CSR_COUNTER_EN
    check("minstret_plus3", bus.r_csr_data_o, 32'd13);
`else
    check("minstret_plus3", bus.r_csr_data_o, 32'd0);
`endif
    tick();

    // Trap entry and mret
    begin_cycle(12'h300);
    write(12'h300, 32'h0000_0008);
    settle();
    tick();
    begin_cycle(12'h300);
    trap_req = 1'b1;
    trap_pc = 32'h0000_0123;
    trap_cause = 32'h8000_0007;
    settle();
    check("pre_trap_mstatus", bus.r_csr_data_o, 32'h8);
    check("pre_trap_gie", {31'd0, global_ie_o}, 32'h1);
    tick();
    begin_cycle(12'h341);
    settle();
    check("trap_mepc_o", mepc_o, 32'h120);
    check("trap_gie", {31'd0, global_ie_o}, 32'h0);
    peek("trap_mcause", 12'h342, 32'h8000_0007);
    peek("trap_mstatus", 12'h300, 32'h80);
    tick();
    begin_cycle(12'h300);
    mret = 1'b1;
    settle();
    tick();
    begin_cycle(12'h300);
    settle();
    check("mret_mstatus", bus.r_csr_data_o, 32'h88);
    tick();

    // Trap, mret and mepc write together: trap wins
    begin_cycle(12'h341);
    trap_req = 1'b1;
    mret = 1'b1;
    trap_pc = 32'h0000_0200;
    trap_cause = 32'd5;
    write(12'h341, 32'h40);
    settle();
    tick();
    begin_cycle(12'h341);
    settle();
    check("conf_mepc", bus.r_csr_data_o, 32'h200);
    peek("conf_mcause", 12'h342, 32'd5);
    peek("conf_mstatus", 12'h300, 32'h80);
    tick();

    // Writes to read-only addresses are dropped
    begin_cycle(12'hC00);
    write(12'hC00, 32'h1234_5678);
    settle();
    tick();
    begin_cycle(12'hF14);
    write(12'hF14, 32'h77);
    settle();
    tick();
    begin_cycle(12'hF14);
    settle();
    check("mhartid_ro", bus.r_csr_data_o, 32'h0);
    peek("unimpl_data", 12'h7C0, 32'h0);
    check("unimpl_illegal", {31'd0, bus.r_csr_illegal_o}, 32'h1);
    tick();

    // Reset in the same cycle as a trap request
    begin_cycle(12'h341);
    rst_n = 1'b0;
    trap_req = 1'b1;
    trap_pc = 32'h0000_0444;
    trap_cause = 32'd2;
    settle();
    tick();
    begin_cycle(12'h341);
    settle();
    check("mrst_mepc", mepc_o, 32'h0);
    check("mrst_mtvec", mtvec_o, 32'h0);
    check("mrst_gie", {31'd0, global_ie_o}, 32'h0);
    peek("mrst_mcause", 12'h342, 32'h0);
    peek("mrst_mcycle", 12'hB00, 32'h0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      begin_cycle(addrs[$urandom_range(0, 19)]);
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      retire = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) begin
        trap_req = 1'b1;
        trap_pc = $urandom;
        trap_cause = $urandom;
      end
      if ($urandom_range(0, 15) == 0) mret = 1'b1;
      if ($urandom_range(0, 2) == 0)
        write(addrs[$urandom_range(0, 19)],
              ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom);
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
